// File: rtl/fdiv_9p5.sv
// Divide-by-N.5 clock divider using both clk edges; default divide-by-9.5.
// Optional `FDIV_PHASE_OUT_EN` exposes the half-cycle phase index on port phase.
module fdiv_9p5 #(
    parameter int DIV_INT     = 9,
    parameter int HIGH_HALVES = 9,
    localparam int PW         = $clog2(2 * DIV_INT + 1)
) (
    input  logic          clk,
    input  logic          clr,
    output logic          clk_div
`ifdef FDIV_PHASE_OUT_EN
    ,
    output logic [PW-1:0] phase
`endif
);

    localparam logic [PW-1:0] HMAX_V = PW'(2 * DIV_INT);
    localparam logic [PW-1:0] HIGH_V = PW'(HIGH_HALVES);

    // Each half of the state lives in one edge domain; the true value is the XOR
    // of both, so only one XOR input ever changes at a time and the output cannot glitch.
    logic          r_run;
    logic [PW-1:0] r_hp;
    logic [PW-1:0] r_hn;
    logic          r_dp;
    logic          r_dn;
    logic [PW-1:0] w_h;
    logic [PW-1:0] w_h_nxt;

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] h);
        logic [PW-1:0] n;
        if (h >= HMAX_V) begin
            n = '0;
        end else begin
            n = h + PW'(1);
        end
        return n;
    endfunction

    function automatic logic is_high(input logic [PW-1:0] h);
        return (h < HIGH_V);
    endfunction

    assign w_h     = r_hp ^ r_hn;
    assign w_h_nxt = next_phase(w_h);

    // Rising-edge half: starts the sequence at h = 0 and advances on every later rise.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_run <= 1'b0;
            r_hp  <= '0;
            r_dp  <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
            r_hp  <= r_hn;
            r_dp  <= is_high('0) ^ r_dn;
        end else begin
            r_run <= 1'b1;
            r_hp  <= w_h_nxt ^ r_hn;
            r_dp  <= is_high(w_h_nxt) ^ r_dn;
        end
    end

    // Falling-edge half: idle until the first qualifying rising edge has been taken.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_hn <= '0;
            r_dn <= 1'b0;
        end else if (r_run) begin
            r_hn <= w_h_nxt ^ r_hp;
            r_dn <= is_high(w_h_nxt) ^ r_dp;
        end else begin
            r_hn <= r_hn;
            r_dn <= r_dn;
        end
    end

    // clr is a controlling 0 on the AND, masking any skew while both halves clear.
    assign clk_div = clr & (r_dp ^ r_dn);

`ifdef FDIV_PHASE_OUT_EN
    assign phase = {PW{clr}} & w_h;
`endif

endmodule

// File: tb/tb_fdiv_9p5.sv
// Self-checking bench for fdiv_9p5: default 9.5 divider and a 2.5 divider in parallel,
// compared against a time-based reference model plus edge-timing tables.
module tb_fdiv_9p5;

    typedef struct {
        longint t;
        logic   lvl;
    } ev_t;

    typedef struct {
        int     idx;
        longint t;
        logic   lvl;
    } exp_ev_t;

    logic clk;
    logic clr;
    logic clk_div0;
    logic clk_div1;
`ifdef FDIV_PHASE_OUT_EN
    logic [4:0] ph0;
    logic [2:0] ph1;
`endif

    int checks   = 0;
    int failures = 0;

    ev_t log0[$];
    ev_t log1[$];

    bit     run0 = 1'b0;
    bit     run1 = 1'b0;
    longint t00  = 0;
    longint t01  = 0;

    fdiv_9p5 dut0 (
        .clk     (clk),
        .clr     (clr),
        .clk_div (clk_div0)
`ifdef FDIV_PHASE_OUT_EN
        ,
        .phase   (ph0)
`endif
    );

    fdiv_9p5 #(.DIV_INT(2), .HIGH_HALVES(2)) dut1 (
        .clk     (clk),
        .clr     (clr),
        .clk_div (clk_div1)
`ifdef FDIV_PHASE_OUT_EN
        ,
        .phase   (ph1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: after the first rising edge with clr high, the output is a pure function
    // of elapsed half-periods (5 ns each) modulo the ratio.
    task automatic model_step(input logic c, input logic r, input longint now,
                              inout bit run, inout longint t0);
        if (!r) begin
            run = 1'b0;
        end else if (!run && c) begin
            run = 1'b1;
            t0  = now;
        end
    endtask

    function automatic longint model_idx(input bit run, input longint t0,
                                         input longint now, input int p);
        return run ? ((now - t0) / 5) % longint'(p) : 0;
    endfunction

    function automatic logic model_div(input bit run, input longint t0,
                                       input longint now, input int p, input int h);
        return run && (model_idx(run, t0, now, p) < longint'(h));
    endfunction

    always @(clk_div0) log0.push_back('{longint'($time), clk_div0});
    always @(clk_div1) log1.push_back('{longint'($time), clk_div1});

    // Sample both DUTs 2 ns after every clk edge and compare with the model.
    always @(clk) begin
        longint now;
        now = longint'($time);
        #2;
        model_step(clk, clr, now, run0, t00);
        model_step(clk, clr, now, run1, t01);
        check("div0_sample", longint'(clk_div0), longint'(model_div(run0, t00, now, 19, 9)));
        check("div1_sample", longint'(clk_div1), longint'(model_div(run1, t01, now, 5, 2)));
`ifdef FDIV_PHASE_OUT_EN
        check("phase0_sample", longint'(ph0), model_idx(run0, t00, now, 19));
        check("phase1_sample", longint'(ph1), model_idx(run1, t01, now, 5));
`endif
    end

    task automatic check_table(input string name, ref ev_t lg[$], input longint from_t,
                               input exp_ev_t tbl[5]);
        ev_t q[$];
        foreach (lg[i]) if (lg[i].t >= from_t) q.push_back(lg[i]);
        for (int i = 0; i < 5; i++) begin
            if (q.size() <= tbl[i].idx) begin
                check({name, "_missing_edge"}, longint'(q.size()), longint'(tbl[i].idx + 1));
            end else begin
                check({name, "_edge_time"}, q[tbl[i].idx].t, tbl[i].t);
                check({name, "_edge_level"}, longint'(q[tbl[i].idx].lvl), longint'(tbl[i].lvl));
            end
        end
    endtask

    task automatic check_pattern(input string name, ref ev_t lg[$], input longint from_t,
                                 input longint to_t, input longint hi, input longint lo);
        ev_t q[$];
        foreach (lg[i]) if (lg[i].t >= from_t && lg[i].t <= to_t) q.push_back(lg[i]);
        check({name, "_enough_edges"}, longint'(q.size() >= 8), 64'd1);
        for (int i = 0; i + 1 < q.size(); i++) begin
            check({name, "_half_len"}, q[i+1].t - q[i].t, q[i].lvl ? hi : lo);
        end
    endtask

    function automatic longint first_rise_after(input longint r);
        return ((r % 10) < 5) ? (r - (r % 10) + 5) : (r - (r % 10) + 15);
    endfunction

    initial begin
        exp_ev_t tbl0[5];
        exp_ev_t tbl1[5];
        ev_t     q[$];
        longint  tr;
        int      n;
        bit      found;

        tbl0[0] = '{0, 15, 1'b1};  tbl0[1] = '{1, 60, 1'b0};  tbl0[2] = '{2, 110, 1'b1};
        tbl0[3] = '{3, 155, 1'b0}; tbl0[4] = '{4, 205, 1'b1};
        tbl1[0] = '{0, 15, 1'b1};  tbl1[1] = '{1, 25, 1'b0};  tbl1[2] = '{2, 40, 1'b1};
        tbl1[3] = '{3, 50, 1'b0};  tbl1[4] = '{4, 65, 1'b1};

        clr = 1'b1;
        #1 clr = 1'b0;
        #10;
        check("reset_div0", longint'(clk_div0), 64'd0);
        check("reset_div1", longint'(clk_div1), 64'd0);
`ifdef FDIV_PHASE_OUT_EN
        check("reset_phase0", longint'(ph0), 64'd0);
`endif
        #2 clr = 1'b1;                       // release at 13 ns, first rise at 15 ns
        #1000;                               // t = 1013
        check_table("tbl0", log0, 13, tbl0);
        check_table("tbl1", log1, 13, tbl1);
        check_pattern("free0", log0, 15, 1013, 45, 50);
        check_pattern("free1", log1, 15, 1013, 10, 15);

        // Reset mid high-phase of the default divider.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (clk_div0 === 1'b1) found = 1'b1;
            else #5;
        end
        check("wait_high_bound", longint'(found), 64'd1);
        clr = 1'b0;
        #1;
        check("midreset_drop0", longint'(clk_div0), 64'd0);
        check("midreset_drop1", longint'(clk_div1), 64'd0);
        #9;
        clr = 1'b1;
        tr  = longint'($time);
        #200;
        q.delete();
        foreach (log0[i]) if (log0[i].t > tr) q.push_back(log0[i]);
        check("restart_edges", longint'(q.size() >= 2), 64'd1);
        if (q.size() >= 2) begin
            check("restart_rise_t", q[0].t, first_rise_after(tr));
            check("restart_rise_lvl", longint'(q[0].lvl), 64'd1);
            check("restart_fall_t", q[1].t, first_rise_after(tr) + 45);
        end

        // Reset while clk low and clk_div low: no activity during reset.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (clk === 1'b0 && clk_div0 === 1'b0) found = 1'b1;
            else #5;
        end
        check("wait_low_bound", longint'(found), 64'd1);
        tr  = longint'($time);
        clr = 1'b0;
        #(5 * $urandom_range(2, 8));
        n = 0;
        foreach (log0[i]) if (log0[i].t > tr) n++;
        check("no_pulse_in_reset", longint'(n), 64'd0);
        clr = 1'b1;

        // Random reset pulses; the sampling model checks everything in between.
        for (int i = 0; i < 12; i++) begin
            #(5 * $urandom_range(1, 80));
            clr = 1'b0;
            #(5 * $urandom_range(1, 4));
            clr = 1'b1;
        end
        #500;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
